// File: rtl/csr_bus_router.sv
// Registered CSR access router: decodes one access at a time onto NUM_TGT target
// windows, waits for the selected target, and returns data, illegal or timeout responses.
module csr_bus_router #(
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_WIDTH      = 32,
    parameter int NUM_TGT        = 4,
    parameter logic [NUM_TGT-1:0][ADDR_WIDTH-1:0] TGT_BASE  = '0,
    parameter logic [NUM_TGT-1:0][ADDR_WIDTH-1:0] TGT_LIMIT = '0,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              csr_valid,
    output logic                              csr_ready,
    input  logic [1:0]                        csr_op,
    input  logic [2:0]                        csr_funct3,
    input  logic [4:0]                        csr_imm,
    input  logic [REG_WIDTH-1:0]              rs1_val,
    input  logic [ADDR_WIDTH-1:0]             csr_addr,
    output logic                              csr_rvalid,
    input  logic                              csr_rready,
    output logic [REG_WIDTH-1:0]              csr_rdata,
    output logic [2:0]                        csr_reg_rsp,
    output logic [NUM_TGT-1:0]                tgt_reg_en,
    output logic [ADDR_WIDTH-1:0]             tgt_addr,
    output logic [4:0]                        tgt_csr_imm,
    output logic [REG_WIDTH-1:0]              tgt_rs1_val,
    output logic [2:0]                        tgt_funct3,
    output logic [1:0]                        tgt_reg_op,
    input  logic [NUM_TGT-1:0]                tgt_rvalid,
    input  logic [NUM_TGT-1:0][REG_WIDTH-1:0] tgt_rdata,
    input  logic [NUM_TGT-1:0][2:0]           tgt_act_rsp
);
    localparam int SEL_W = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_t;

    state_t                  state_q;
    logic [SEL_W-1:0]        sel_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    rvalid_q;
    logic [REG_WIDTH-1:0]    rdata_q;
    logic [2:0]              rsp_q;
    logic [NUM_TGT-1:0]      reg_en_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [4:0]              imm_q;
    logic [REG_WIDTH-1:0]    rs1_q;
    logic [2:0]              funct3_q;
    logic [1:0]              op_q;

    logic [NUM_TGT-1:0]      hit;
    logic                    any_hit;
    logic [SEL_W-1:0]        hit_idx;

    // Window compare via borrow bits, so an all-zero base folds cleanly.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_TGT; gi++) begin : g_decode
            logic [ADDR_WIDTH:0] diff_lo;
            logic [ADDR_WIDTH:0] diff_hi;
            assign diff_lo = {1'b0, csr_addr} - {1'b0, TGT_BASE[gi]};
            assign diff_hi = {1'b0, TGT_LIMIT[gi]} - {1'b0, csr_addr};
            assign hit[gi] = ~diff_lo[ADDR_WIDTH] & ~diff_hi[ADDR_WIDTH];
        end
    endgenerate

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        any_hit = 1'b0;
        hit_idx = '0;
        for (int i = NUM_TGT - 1; i >= 0; i--) begin
            if (hit[i]) begin
                any_hit = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
    end

    logic                 sel_rvalid;
    logic [REG_WIDTH-1:0] sel_rdata;
    logic [2:0]           sel_rsp;
    assign sel_rvalid = tgt_rvalid[sel_q];
    assign sel_rdata  = tgt_rdata[sel_q];
    assign sel_rsp    = tgt_act_rsp[sel_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rsp_q    <= '0;
            reg_en_q <= '0;
            addr_q   <= '0;
            imm_q    <= '0;
            rs1_q    <= '0;
            funct3_q <= '0;
            op_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (csr_valid) begin
                        addr_q   <= csr_addr;
                        imm_q    <= csr_imm;
                        rs1_q    <= rs1_val;
                        funct3_q <= csr_funct3;
                        op_q     <= csr_op;
                        if (any_hit) begin
                            sel_q    <= hit_idx;
                            reg_en_q <= NUM_TGT'(1) << hit_idx;
                            state_q  <= REQ;
                        end else begin
                            rvalid_q <= 1'b1;
                            rdata_q  <= '0;
                            rsp_q    <= 3'b110;
                            state_q  <= RSP;
                        end
                    end
                end
                REQ: begin
                    reg_en_q <= '0;
                    if (sel_rvalid) begin
                        rdata_q  <= sel_rdata;
                        rsp_q    <= sel_rsp;
                        rvalid_q <= 1'b1;
                        state_q  <= RSP;
                    end else begin
                        cnt_q   <= CNT_W'(1);
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (sel_rvalid) begin
                        rdata_q  <= sel_rdata;
                        rsp_q    <= sel_rsp;
                        rvalid_q <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= RSP;
                    end else if (cnt_q == CNT_LAST) begin
                        rdata_q  <= '0;
                        rsp_q    <= 3'b111;
                        rvalid_q <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= RSP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RSP: begin
                    if (csr_rready) begin
                        rvalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign csr_ready   = (state_q == IDLE);
    assign csr_rvalid  = rvalid_q;
    assign csr_rdata   = rdata_q;
    assign csr_reg_rsp = rsp_q;
    assign tgt_reg_en  = reg_en_q;
    assign tgt_addr    = addr_q;
    assign tgt_csr_imm = imm_q;
    assign tgt_rs1_val = rs1_q;
    assign tgt_funct3  = funct3_q;
    assign tgt_reg_op  = op_q;

endmodule

// File: tb/tb_csr_bus_router.sv
// Directed bench for csr_bus_router: vector table of single accesses plus
// hand sequences for response back-pressure, late responses and mid-access reset.
module tb_csr_bus_router;
    localparam int AW = 32;
    localparam int RW = 32;
    localparam int NT = 4;
    localparam logic [NT-1:0][AW-1:0] BASE  = {32'h3C0, 32'h200, 32'h100, 32'h3A0};
    localparam logic [NT-1:0][AW-1:0] LIMIT = {32'h3FF, 32'h2FF, 32'h1FF, 32'h3EF};

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 csr_valid;
    logic                 csr_ready;
    logic [1:0]           csr_op;
    logic [2:0]           csr_funct3;
    logic [4:0]           csr_imm;
    logic [RW-1:0]        rs1_val;
    logic [AW-1:0]        csr_addr;
    logic                 csr_rvalid;
    logic                 csr_rready;
    logic [RW-1:0]        csr_rdata;
    logic [2:0]           csr_reg_rsp;
    logic [NT-1:0]        tgt_reg_en;
    logic [AW-1:0]        tgt_addr;
    logic [4:0]           tgt_csr_imm;
    logic [RW-1:0]        tgt_rs1_val;
    logic [2:0]           tgt_funct3;
    logic [1:0]           tgt_reg_op;
    logic [NT-1:0]        tgt_rvalid;
    logic [NT-1:0][RW-1:0] tgt_rdata;
    logic [NT-1:0][2:0]   tgt_act_rsp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    csr_bus_router #(
        .ADDR_WIDTH(AW), .REG_WIDTH(RW), .NUM_TGT(NT),
        .TGT_BASE(BASE), .TGT_LIMIT(LIMIT), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst),
        .csr_valid(csr_valid), .csr_ready(csr_ready),
        .csr_op(csr_op), .csr_funct3(csr_funct3), .csr_imm(csr_imm),
        .rs1_val(rs1_val), .csr_addr(csr_addr),
        .csr_rvalid(csr_rvalid), .csr_rready(csr_rready),
        .csr_rdata(csr_rdata), .csr_reg_rsp(csr_reg_rsp),
        .tgt_reg_en(tgt_reg_en), .tgt_addr(tgt_addr),
        .tgt_csr_imm(tgt_csr_imm), .tgt_rs1_val(tgt_rs1_val),
        .tgt_funct3(tgt_funct3), .tgt_reg_op(tgt_reg_op),
        .tgt_rvalid(tgt_rvalid), .tgt_rdata(tgt_rdata), .tgt_act_rsp(tgt_act_rsp)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic [1:0]    op;
        logic [2:0]    f3;
        logic [4:0]    imm;
        logic [RW-1:0] rs1;
        int            tgt;      // -1: no target expected
        int            lat;      // cycles after REQ before rvalid; -1: never
        logic [RW-1:0] rdata;
        logic [2:0]    act;
        logic [NT-1:0] stray;    // rvalid noise on non-selected targets
        logic [NT-1:0] exp_en;
        int            exp_cyc;
        logic [RW-1:0] exp_rdata;
        logic [2:0]    exp_rsp;
    } vec_t;

    vec_t vecs[8];

    function automatic vec_t mk(input logic [AW-1:0] addr, input logic [1:0] op,
                                input int tgt, input int lat, input logic [RW-1:0] rdata,
                                input logic [2:0] act, input logic [NT-1:0] stray,
                                input logic [NT-1:0] exp_en, input int exp_cyc,
                                input logic [RW-1:0] exp_rdata, input logic [2:0] exp_rsp);
        vec_t v;
        v.addr = addr; v.op = op; v.f3 = 3'(addr[2:0] ^ 3'b101); v.imm = addr[6:2];
        v.rs1 = ~addr; v.tgt = tgt; v.lat = lat; v.rdata = rdata; v.act = act;
        v.stray = stray; v.exp_en = exp_en; v.exp_cyc = exp_cyc;
        v.exp_rdata = exp_rdata; v.exp_rsp = exp_rsp;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int            req_cyc = -1;
        int            rsp_cyc = -1;
        int            en_cnt = 0;
        logic [NT-1:0] en_seen = '0;
        logic [RW-1:0] got_d = '0;
        logic [2:0]    got_r = '0;
        @(negedge clk);
        csr_valid = 1'b1; csr_addr = v.addr; csr_op = v.op; csr_funct3 = v.f3;
        csr_imm = v.imm; rs1_val = v.rs1; csr_rready = 1'b1; tgt_rvalid = '0;
        for (int t = 0; t < NT; t++) begin
            tgt_rdata[t] = 32'hBAD0_0000 | t;
            tgt_act_rsp[t] = 3'b011;
        end
        if (v.tgt >= 0) begin
            tgt_rdata[v.tgt] = v.rdata;
            tgt_act_rsp[v.tgt] = v.act;
        end
        for (int cyc = 1; cyc <= 40 && rsp_cyc < 0; cyc++) begin
            @(negedge clk);
            csr_valid = 1'b0;
            if (tgt_reg_en != '0) begin
                en_seen |= tgt_reg_en;
                en_cnt++;
                req_cyc = cyc;
                chk("bcast_addr", 64'(tgt_addr), 64'(v.addr));
                chk("bcast_rs1", 64'(tgt_rs1_val), 64'(v.rs1));
                chk("bcast_fields", 64'({tgt_reg_op, tgt_funct3, tgt_csr_imm}),
                    64'({v.op, v.f3, v.imm}));
            end
            if (csr_rvalid) begin
                rsp_cyc = cyc;
                got_d = csr_rdata;
                got_r = csr_reg_rsp;
                tgt_rvalid = '0;
            end else begin
                tgt_rvalid = v.stray;
                if (v.tgt >= 0 && v.lat >= 0 && req_cyc > 0 && cyc == req_cyc + v.lat)
                    tgt_rvalid[v.tgt] = 1'b1;
            end
        end
        chk("reg_en_mask", 64'(en_seen), 64'(v.exp_en));
        chk("reg_en_cycles", 64'(en_cnt), (v.exp_en != '0) ? 64'd1 : 64'd0);
        chk("rsp_cycle", 64'(rsp_cyc), 64'(v.exp_cyc));
        chk("rsp_rdata", 64'(got_d), 64'(v.exp_rdata));
        chk("rsp_code", 64'(got_r), 64'(v.exp_rsp));
        @(negedge clk);
        chk("post_rvalid", 64'(csr_rvalid), 64'd0);
        chk("post_ready", 64'(csr_ready), 64'd1);
        $display("vec %0d addr=0x%0h en=%b cyc=%0d rdata=0x%0h rsp=%b", idx, v.addr,
                 en_seen, rsp_cyc, got_d, got_r);
    endtask

    initial begin
        vecs[0] = mk(32'h3A5, 2'b10,  0,  0, 32'hDEADBEEF, 3'b000, 4'b0000, 4'b0001,  2, 32'hDEADBEEF, 3'b000);
        vecs[1] = mk(32'h7C0, 2'b10, -1, -1, 32'h0,        3'b000, 4'b0000, 4'b0000,  1, 32'h0,        3'b110);
        vecs[2] = mk(32'h150, 2'b11,  1, -1, 32'h0,        3'b000, 4'b1101, 4'b0010, 17, 32'h0,        3'b111);
        vecs[3] = mk(32'h2FF, 2'b01,  2, 15, 32'h12345678, 3'b010, 4'b1000, 4'b0100, 17, 32'h12345678, 3'b010);
        vecs[4] = mk(32'h3EF, 2'b10,  0,  3, 32'h0000A5A5, 3'b000, 4'b1110, 4'b0001,  5, 32'h0000A5A5, 3'b000);
        vecs[5] = mk(32'h3F0, 2'b11,  3,  1, 32'hCAFE0003, 3'b101, 4'b0000, 4'b1000,  3, 32'hCAFE0003, 3'b101);
        vecs[6] = mk(32'h39F, 2'b10, -1, -1, 32'h0,        3'b000, 4'b1111, 4'b0000,  1, 32'h0,        3'b110);
        vecs[7] = mk(32'h100, 2'b01,  1, 14, 32'h600DD00D, 3'b001, 4'b0001, 4'b0010, 16, 32'h600DD00D, 3'b001);

        rst = 1'b1; csr_valid = 1'b0; csr_op = '0; csr_funct3 = '0; csr_imm = '0;
        rs1_val = '0; csr_addr = '0; csr_rready = 1'b0;
        tgt_rvalid = '0; tgt_rdata = '0; tgt_act_rsp = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(csr_ready), 64'd1);
        chk("rst_rvalid", 64'(csr_rvalid), 64'd0);
        chk("rst_reg_en", 64'(tgt_reg_en), 64'd0);
        chk("rst_bcast", 64'({tgt_addr, tgt_reg_op, tgt_funct3, tgt_csr_imm}), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Late answer from a target after its access already timed out.
        run_vec(vecs[2], 2);
        tgt_rvalid = 4'b0010;
        @(negedge clk);
        chk("late_rvalid", 64'(csr_rvalid), 64'd0);
        chk("late_ready", 64'(csr_ready), 64'd1);
        tgt_rvalid = '0;

        // Response held under back-pressure; a pending request waits for the handshake.
        @(negedge clk);
        csr_valid = 1'b1; csr_addr = 32'h3A5; csr_op = 2'b10; csr_rready = 1'b0;
        tgt_rdata[0] = 32'h11112222; tgt_act_rsp[0] = 3'b000;
        tgt_rdata[1] = 32'h00000055; tgt_act_rsp[1] = 3'b000;
        @(negedge clk);
        csr_valid = 1'b0; tgt_rvalid = 4'b0001;
        @(negedge clk);
        tgt_rvalid = '0;
        chk("bp_rvalid0", 64'(csr_rvalid), 64'd1);
        csr_valid = 1'b1; csr_addr = 32'h150; tgt_rdata[0] = 32'h0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold", 64'({csr_rvalid, csr_ready, csr_reg_rsp, csr_rdata}),
                64'({1'b1, 1'b0, 3'b000, 32'h11112222}));
            chk("bp_no_accept", 64'({tgt_reg_en, tgt_addr}), 64'({4'b0000, 32'h3A5}));
        end
        csr_rready = 1'b1;
        @(negedge clk);
        chk("bp_idle", 64'({csr_rvalid, csr_ready, tgt_reg_en}), 64'({1'b0, 1'b1, 4'b0000}));
        @(negedge clk);
        chk("bp_next_req", 64'({tgt_reg_en, tgt_addr}), 64'({4'b0010, 32'h150}));
        csr_valid = 1'b0; tgt_rvalid = 4'b0010;
        @(negedge clk);
        tgt_rvalid = '0;
        chk("bp_next_rsp", 64'({csr_rvalid, csr_rdata}), 64'({1'b1, 32'h55}));
        @(negedge clk);
        chk("bp_next_done", 64'(csr_rvalid), 64'd0);
        $display("seq backpressure done");

        // Reset while waiting on a silent target.
        @(negedge clk);
        csr_valid = 1'b1; csr_addr = 32'h150; csr_op = 2'b11; csr_imm = 5'h1F;
        csr_funct3 = 3'b111; rs1_val = 32'hFFFF0000;
        @(negedge clk);
        csr_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("wrst_rsp", 64'({csr_rvalid, csr_reg_rsp, csr_rdata}), 64'd0);
        chk("wrst_bcast", 64'({tgt_reg_en, tgt_reg_op, tgt_funct3, tgt_csr_imm, tgt_addr}), 64'd0);
        chk("wrst_rs1", 64'(tgt_rs1_val), 64'd0);
        chk("wrst_ready", 64'(csr_ready), 64'd1);
        tgt_rvalid = 4'b0010;
        @(negedge clk);
        tgt_rvalid = '0;
        chk("wrst_late", 64'({csr_rvalid, csr_ready}), 64'({1'b0, 1'b1}));
        $display("seq reset-in-wait done");
        run_vec(vecs[0], 0);
        run_vec(vecs[7], 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
